pes_ripco_ctrl: RTL
===================

# pes_ripco_ctrl

Synchronous sequencer for the team's small counters: it loads a programmable period, runs a fully synchronous count, emits a one-cycle terminal `tick`, and reports completion through a done/ack handshake. It replaces ad-hoc ripple-clocked counting wherever downstream logic needs an event on the main clock domain. It supports one-shot and periodic modes and sits between a control register block and any consumer of periodic strobes.

## Interface
- `WIDTH`, default 8: width of the period and count.
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high; sampled on the `clk` rising edge.
- `start` input, 1 bit: request to begin a run; honoured only in IDLE.
- `stop` input, 1 bit: abort the run; honoured only in RUN.
- `mode_periodic` input, 1 bit: 1 selects periodic mode, 0 selects one-shot; latched at start.
- `period` input, WIDTH bits: number of cycles per tick; latched at start; 0 is illegal.
- `ack` input, 1 bit: acknowledges `done`; honoured only in DONE.
- `busy` output, 1 bit: high while in RUN.
- `count` output, WIDTH bits: current count value.
- `tick` output, 1 bit: one-cycle pulse on the terminal count.
- `done` output, 1 bit: level, high in DONE (one-shot completion only).
- `err` output, 1 bit: one-cycle pulse when `start` is seen with `period == 0`.

## Operation
- States are IDLE, RUN and DONE.
- **IDLE**
  - `count = 0`.
  - `start && period != 0`: latch `period` into `period_q` and `mode_periodic` into `mode_q`, clear `count`, go to RUN.
  - `start && period == 0`: `err = 1` for one cycle, stay in IDLE.
- **RUN**
  - `count` increments by 1 each cycle.
  - `tick = (state == RUN) && (count == period_q - 1)`. This is a combinational decode of registered state.
  - At terminal count with `mode_q = 1`: `count` wraps to 0 and the block stays in RUN.
  - At terminal count with `mode_q = 0`: go to DONE and clear `count`.
  - `stop`: go to IDLE and clear `count`. `stop` has priority over the terminal transition. `tick` still asserts if this is the terminal cycle.
  - `start` and `ack` are ignored.
  - Changes to `period` and `mode_periodic` have no effect until the next start.
- **DONE**
  - `done = 1`, `count = 0`.
  - `ack`: go to IDLE.
  - `start` is ignored, including a `start` in the same cycle as `ack`.
  - `stop` is ignored.
- Arithmetic: `count` never exceeds `period_q - 1`, so no overflow is possible. `period = 2^WIDTH - 1` is legal.
- Reset: synchronous, any state → IDLE. `count`, `busy`, `tick`, `done` and `err` are all 0 after the reset edge. Reset mid-run discards the run with no tick. Reset has priority over all other inputs.

## Timing
- `start` sampled at edge k: `busy = 1` and `count = 0` from edge k.
- First `tick` occurs in the cycle after edge k+P−1, i.e. P cycles after acceptance.
- Periodic mode: `tick` repeats every P cycles with no gap. With P = 1, `tick` is high every RUN cycle.
- One-shot mode: `done` rises at the edge after the tick cycle, and `busy` falls at the same edge.
- `ack` sampled at edge m: `done = 0` from edge m. The earliest next accepted `start` is at edge m+1.
- `stop` sampled at edge s: `busy = 0` and `count = 0` from edge s.
- Output sources:
  - `err` is registered and pulses the cycle after the offending `start`.
  - `tick` is combinational from registers.
  - All other outputs are registered.

## Structure
- Shared package `pes_ctrl_pkg` contains:
  - the state encoding: IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10, with 2'b11 recovering to IDLE;
  - the default WIDTH constant.
- Sub-module `pes_cnt_core`:
  - WIDTH-bit register with synchronous `clr`/`en`;
  - terminal compare against `period_q` producing `term`.
- The top level holds the FSM, the `period_q`/`mode_q` latches and the `err` register.

## Test plan
- Reset, then one-shot with `period = 4`: `tick` in the 4th cycle after acceptance, `done` the next cycle; `ack` → IDLE with `count = 0`.
- Periodic with `period = 3` for 10 cycles: `tick` at cycles 3, 6 and 9; `count` sequence 0,1,2,0,1,2…; `busy` held high.
- `start` with `period = 0`: single-cycle `err`, `busy` stays 0; a `start` with `period = 1` in periodic mode then gives `tick` every cycle.
- `stop` on the terminal cycle in one-shot mode with `period = 5`: `tick = 1` that cycle, next state is IDLE, `done` never asserts.
- `period` changed from 4 to 7 mid-run and a second `start` asserted while busy: tick spacing stays at 4 and the extra `start` is ignored; `start` together with `ack` in DONE does not begin a run.
- Synchronous `reset` mid-RUN at `count = 2` with `period = 8`: after that edge all outputs are 0 and no `tick` occurs; asserting `reset` without a clock edge changes nothing.

Source files
------------

// File: rtl/pes_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pes_ctrl_pkg
// Description : Shared constants for the pes_ripco_ctrl sequencer: the FSM
//               state encoding and the default counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package pes_ctrl_pkg;

    // Default width of the period and the count
    localparam int c_DEFAULT_WIDTH = 8;

    // Sequencer state encoding; the unused code 2'b11 recovers to IDLE
    localparam logic [1:0] c_IDLE = 2'b00;
    localparam logic [1:0] c_RUN  = 2'b01;
    localparam logic [1:0] c_DONE = 2'b10;

endpackage : pes_ctrl_pkg
`default_nettype wire

// File: rtl/pes_cnt_core.sv
`default_nettype none
// ============================================================================
// Module      : pes_cnt_core
// Description : WIDTH-bit synchronous counter with clear/enable and a terminal
//               compare against the latched period (term = count == period-1).
// Revision    : 1.0 - initial release
// ============================================================================
module pes_cnt_core
    import pes_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] period_q,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    logic [WIDTH-1:0] r_count;

    // Count register: clear wins over enable, enable advances by one
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
    // Period is never 0 while counting, so period-1 cannot underflow in use
    assign term  = (r_count == (period_q - WIDTH'(1)));

endmodule : pes_cnt_core
`default_nettype wire

// File: rtl/pes_ripco_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pes_ripco_ctrl
// Description : Synchronous period sequencer. Loads a period on start, counts
//               on the main clock, emits a one-cycle terminal tick and, in
//               one-shot mode, reports completion with a done/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module pes_ripco_ctrl
    import pes_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode_periodic,
    input  logic [WIDTH-1:0] period,
    input  logic             ack,
    output logic             busy,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             done,
    output logic             err
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_period_q;
    logic             r_mode_q;
    logic             r_busy;
    logic             r_done;
    logic             r_err;

    logic             w_run;
    logic             w_term;
    logic             w_cnt_clr;
    logic             w_cnt_en;

    // Counting only happens in RUN; every other state holds the count at 0.
    // In RUN the terminal cycle clears (wrap or completion), as does stop.
    assign w_run     = (r_state == c_RUN);
    assign w_cnt_clr = ~w_run | stop | w_term;
    assign w_cnt_en  = w_run;

    pes_cnt_core #(
        .WIDTH    (WIDTH)
    ) u_cnt_core (
        .clk      (clk),
        .reset    (reset),
        .clr      (w_cnt_clr),
        .en       (w_cnt_en),
        .period_q (r_period_q),
        .count    (count),
        .term     (w_term)
    );

    // Sequencer FSM with registered busy/done/err and the start-time latches
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_period_q <= '0;
            r_mode_q   <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (period != '0) begin
                            r_period_q <= period;
                            r_mode_q   <= mode_periodic;
                            r_state    <= c_RUN;
                            r_busy     <= 1'b1;
                        end else begin
                            r_err      <= 1'b1;
                        end
                    end
                end
                c_RUN: begin
                    // stop outranks the terminal transition
                    if (stop) begin
                        r_state <= c_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_term && !r_mode_q) begin
                        r_state <= c_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                c_DONE: begin
                    if (ack) begin
                        r_state <= c_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
    assign tick = w_run & w_term;

endmodule : pes_ripco_ctrl
`default_nettype wire
